// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined MAC adder tree: width helpers,
// accumulator state encodings and the flag bundle that travels with each beat.
package mac_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_flags_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  // Number of terms entering tree level `level` (0 = raw products).
  function automatic int level_terms(input int n, input int level);
    int t;
    t = n;
    for (int i = 0; i < level; i++) begin
      t = (t + 1) / 2;
    end
    return t;
  endfunction

  function automatic int out_width(input int input_size, input int tree_layers,
                                   input int acc_extra);
    return input_size + tree_layers + acc_extra;
  endfunction

endpackage

// File: rtl/mac_accum_tree_pipelined_if.sv
// Streaming beat bus into the MAC tree and frame-result bus out of it.
interface mac_accum_tree_pipelined_if #(
  parameter int NUM_INPUTS = 5,
  parameter int INPUT_SIZE = 59,
  parameter int OUT_W      = 66
);

  logic                             in_valid;
  logic                             in_first;
  logic                             in_last;
  logic [NUM_INPUTS*INPUT_SIZE-1:0] in_data;
  logic                             out_valid;
  logic [OUT_W-1:0]                 out_data;
  logic                             frame_err;
  logic                             acc_ovf;

  modport master (
    output in_valid, in_first, in_last, in_data,
    input  out_valid, out_data, frame_err, acc_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data,
    output out_valid, out_data, frame_err, acc_ovf
  );

endinterface

// File: rtl/adder_tree_level.sv
// One registered pairwise-reduction level of the adder tree; an odd leftover
// term is sign-extended and registered without an add.
module adder_tree_level
  import mac_pkg::*;
#(
  parameter int N_TERMS = 5,
  parameter int W       = 59
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  beat_flags_t                        flags_i,
  input  logic [N_TERMS*W-1:0]               data_i,
  output beat_flags_t                        flags_o,
  output logic [((N_TERMS+1)/2)*(W+1)-1:0]   data_o
);

  localparam int N_OUT = (N_TERMS + 1) / 2;

  logic [N_OUT*(W+1)-1:0] data_d;
  logic [N_OUT*(W+1)-1:0] data_q;
  beat_flags_t            flags_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_pair
    logic [W:0] lo_ext;
    assign lo_ext = {data_i[2*k*W+W-1], data_i[2*k*W +: W]};

    if (2*k + 1 < N_TERMS) begin : g_add
      logic [W:0] hi_ext;
      assign hi_ext = {data_i[(2*k+1)*W+W-1], data_i[(2*k+1)*W +: W]};
      assign data_d[k*(W+1) +: W+1] = lo_ext + hi_ext;
    end else begin : g_pass
      assign data_d[k*(W+1) +: W+1] = lo_ext;
    end
  end

  // Only the flags need reset; data is qualified by valid downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_i;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign flags_o = flags_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mac_accum_tree_pipelined.sv
// Pipelined signed adder tree feeding a multi-beat frame accumulator with
// sticky framing-error and beat-overflow flags.
module mac_accum_tree_pipelined
  import mac_pkg::*;
#(
  parameter int NUM_INPUTS  = 5,
  parameter int INPUT_SIZE  = 59,
  parameter int TREE_LAYERS = 3,
  parameter int ACC_EXTRA   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mac_accum_tree_pipelined_if.slave  bus_if
);

  localparam int OUT_W = out_width(INPUT_SIZE, TREE_LAYERS, ACC_EXTRA);
  localparam int SUM_W = INPUT_SIZE + TREE_LAYERS;
  localparam int CNT_W = ACC_EXTRA + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(2 ** ACC_EXTRA);

  if (NUM_INPUTS < 2 || TREE_LAYERS != clog2(NUM_INPUTS)) begin : g_param_check
    $error("mac_accum_tree_pipelined: TREE_LAYERS must equal clog2(NUM_INPUTS), NUM_INPUTS >= 2");
  end

  for (genvar l = 1; l <= TREE_LAYERS; l++) begin : g_lvl
    localparam int NT = level_terms(NUM_INPUTS, l - 1);
    localparam int WI = INPUT_SIZE + l - 1;
    localparam int NO = (NT + 1) / 2;

    logic [NT*WI-1:0]     lvl_in;
    logic [NO*(WI+1)-1:0] lvl_out;
    beat_flags_t          flags_in;
    beat_flags_t          flags_out;

    if (l == 1) begin : g_src
      assign lvl_in   = bus_if.in_data;
      assign flags_in = '{valid: bus_if.in_valid, first: bus_if.in_first, last: bus_if.in_last};
    end else begin : g_chain
      assign lvl_in   = g_lvl[l-1].lvl_out;
      assign flags_in = g_lvl[l-1].flags_out;
    end

    adder_tree_level #(
      .N_TERMS (NT),
      .W       (WI)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .flags_i (flags_in),
      .data_i  (lvl_in),
      .flags_o (flags_out),
      .data_o  (lvl_out)
    );
  end

  logic [SUM_W-1:0] tree_sum;
  beat_flags_t      tree_flags;

  assign tree_sum   = g_lvl[TREE_LAYERS].lvl_out;
  assign tree_flags = g_lvl[TREE_LAYERS].flags_out;

  logic [0:0]       state_d,     state_q;
  logic [OUT_W-1:0] acc_d,       acc_q;
  logic [CNT_W-1:0] cnt_d,       cnt_q;
  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] out_data_d,  out_data_q;
  logic             frame_err_d, frame_err_q;
  logic             acc_ovf_d,   acc_ovf_q;

  logic [OUT_W-1:0] sum_ext;
  logic [OUT_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_idle;
  logic             start_beat;
  logic             framing_bad;
  logic             ovf_hit;

  assign sum_ext    = {{ACC_EXTRA{tree_sum[SUM_W-1]}}, tree_sum};
  assign in_idle    = (state_q == ST_IDLE);
  // A beat in IDLE always opens a frame, even without first; first in ACCUM restarts.
  assign start_beat  = in_idle || tree_flags.first;
  assign framing_bad = (in_idle && !tree_flags.first) || (!in_idle && tree_flags.first);
  assign acc_sum     = start_beat ? sum_ext : (acc_q + sum_ext);
  assign cnt_base    = start_beat ? '0 : cnt_q;
  assign cnt_inc     = (cnt_base == '1) ? cnt_base : (cnt_base + CNT_W'(1));
  assign ovf_hit     = (cnt_base >= CNT_LIMIT);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    frame_err_d = frame_err_q;
    acc_ovf_d   = acc_ovf_q;

    if (tree_flags.valid) begin
      if (framing_bad) begin
        frame_err_d = 1'b1;
      end
      if (ovf_hit) begin
        acc_ovf_d = 1'b1;
      end
      acc_d = acc_sum;
      if (tree_flags.last) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_sum;
        state_d     = ST_IDLE;
        cnt_d       = '0;
      end else begin
        state_d = ST_ACCUM;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.frame_err = frame_err_q;
  assign bus_if.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_mac_accum_tree_pipelined.sv
// Self-checking bench: table of single-beat frames plus hand-written framing,
// overflow and reset sequences, with a latency-stamped result scoreboard.
module tb_mac_accum_tree_pipelined;

  localparam int NI = 5;
  localparam int IW = 59;
  localparam int OW = 66;

  localparam logic signed [IW-1:0] PMAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] PMIN = {1'b1, {(IW-1){1'b0}}};

  typedef struct {
    logic              first;
    logic              last;
    logic [NI*IW-1:0]  data;
    logic signed [OW-1:0] expected;
  } vec_t;

  typedef struct {
    logic signed [OW-1:0] data;
    int                   due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t vecs[8];

  mac_accum_tree_pipelined_if #(.NUM_INPUTS(NI), .INPUT_SIZE(IW), .OUT_W(OW)) bus ();

  mac_accum_tree_pipelined #(
    .NUM_INPUTS  (NI),
    .INPUT_SIZE  (IW),
    .TREE_LAYERS (3),
    .ACC_EXTRA   (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [NI*IW-1:0] packProducts(input logic signed [IW-1:0] p0,
      input logic signed [IW-1:0] p1, input logic signed [IW-1:0] p2,
      input logic signed [IW-1:0] p3, input logic signed [IW-1:0] p4);
    return {p4, p3, p2, p1, p0};
  endfunction

  function automatic logic [NI*IW-1:0] allSame(input logic signed [IW-1:0] p);
    return {NI{p}};
  endfunction

  task automatic checkOutput(input string name, input logic [OW-1:0] actual,
                             input logic [OW-1:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
    end
  endtask

  task automatic monitorCycle();
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out_valid: actual 1 required 0 (out_data %0h)", bus.out_data);
      end else begin
        e = sbq.pop_front();
        checkOutput("out_data", bus.out_data, e.data);
        checkOutput("out_latency_cycle", OW'(cycle), OW'(e.due));
      end
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    monitorCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  // Result is due four cycles after the cycle in which the last beat is presented.
  task automatic applyStimulus(input logic first, input logic last, input logic [NI*IW-1:0] data,
                               input logic signed [OW-1:0] expected, input bit push);
    exp_t e;
    nextCycle();
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_last  = last;
    bus.in_data  = data;
    if (push) begin
      e.data = expected;
      e.due  = cycle + 4;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 40) begin
      idleCycles(1);
      waited++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
    idleCycles(4);
  endtask

  task automatic doReset();
    nextCycle();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    nextCycle();
    checkOutput("reset_out_valid", OW'(bus.out_valid), '0);
    checkOutput("reset_out_data", bus.out_data, '0);
    checkOutput("reset_frame_err", OW'(bus.frame_err), '0);
    checkOutput("reset_acc_ovf", OW'(bus.acc_ovf), '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;

    vecs[0] = '{1'b1, 1'b1, allSame(-59'sd1), -66'sd5};
    vecs[1] = '{1'b1, 1'b1, allSame(PMAX), 66'sd1441151880758558715};
    vecs[2] = '{1'b1, 1'b1, allSame(PMIN), -66'sd1441151880758558720};
    vecs[3] = '{1'b1, 1'b1, packProducts(59'sd1, 59'sd2, 59'sd3, 59'sd4, 59'sd5), 66'sd15};
    vecs[4] = '{1'b1, 1'b1, packProducts(PMAX, PMIN, 59'sd0, 59'sd0, 59'sd7), 66'sd6};
    vecs[5] = '{1'b1, 1'b1, packProducts(-59'sd100, 59'sd50, 59'sd25, 59'sd25, 59'sd0), 66'sd0};
    vecs[6] = '{1'b1, 1'b1, packProducts(59'sd0, 59'sd0, 59'sd0, 59'sd0, -59'sd1), -66'sd1};
    vecs[7] = '{1'b1, 1'b1, packProducts(59'sd3, -59'sd8, 59'sd100, -59'sd1, 59'sd40), 66'sd134};

    repeat (2) @(negedge clk);
    doReset();

    applyStimulus(1'b1, 1'b1, allSame(59'sd1), 66'sd5, 1'b1);
    drain();
    checkOutput("single_beat_frame_err", OW'(bus.frame_err), '0);
    checkOutput("out_data_held", bus.out_data, 66'sd5);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].first, vecs[i].last, vecs[i].data, vecs[i].expected, 1'b1);
    end
    drain();
    checkOutput("table_frame_err", OW'(bus.frame_err), '0);
    checkOutput("table_out_data_held", bus.out_data, 66'sd134);

    applyStimulus(1'b1, 1'b0, allSame(59'sd2), '0, 1'b0);
    applyStimulus(1'b0, 1'b0, allSame(59'sd2), '0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, allSame(59'sd2), 66'sd30, 1'b1);
    drain();
    checkOutput("gap_frame_err", OW'(bus.frame_err), '0);

    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i == 0, i == 15, allSame(59'sd1), 66'sd80, i == 15);
    end
    drain();
    checkOutput("frame16_acc_ovf", OW'(bus.acc_ovf), '0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(i == 0, i == 16, allSame(59'sd1), 66'sd85, i == 16);
    end
    drain();
    checkOutput("frame17_acc_ovf", OW'(bus.acc_ovf), 66'd1);
    checkOutput("frame17_frame_err", OW'(bus.frame_err), '0);

    doReset();
    applyStimulus(1'b0, 1'b1, allSame(59'sd1), 66'sd5, 1'b1);
    drain();
    checkOutput("idle_nofirst_frame_err", OW'(bus.frame_err), 66'd1);
    applyStimulus(1'b1, 1'b1, packProducts(59'sd1, 59'sd2, 59'sd3, 59'sd4, 59'sd5), 66'sd15, 1'b1);
    drain();
    checkOutput("frame_err_sticky", OW'(bus.frame_err), 66'd1);

    doReset();
    applyStimulus(1'b1, 1'b0, allSame(59'sd3), '0, 1'b0);
    applyStimulus(1'b1, 1'b1, allSame(59'sd1), 66'sd5, 1'b1);
    drain();
    checkOutput("restart_frame_err", OW'(bus.frame_err), 66'd1);

    doReset();
    applyStimulus(1'b1, 1'b0, allSame(59'sd7), '0, 1'b0);
    applyStimulus(1'b0, 1'b0, allSame(59'sd7), '0, 1'b0);
    applyStimulus(1'b0, 1'b1, allSame(59'sd7), '0, 1'b0);
    idleCycles(1);
    doReset();
    idleCycles(8);
    checkOutput("post_abort_out_valid", OW'(bus.out_valid), '0);
    applyStimulus(1'b1, 1'b1, packProducts(59'sd1, 59'sd2, 59'sd3, 59'sd4, 59'sd5), 66'sd15, 1'b1);
    drain();
    checkOutput("post_abort_frame_err", OW'(bus.frame_err), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
